// File: rtl/health_round_ctrl.sv
// Round and match sequencer for a two-player fighter: health, round timer, KO
// detection, win tally and match result. All state advances only on SCEN frames.
module health_round_ctrl #(
    parameter int unsigned HEALTH       = 100,
    parameter int unsigned DMG_LIGHT    = 8,
    parameter int unsigned DMG_HEAVY    = 15,
    parameter int unsigned ROUND_SECS   = 99,
    parameter int unsigned FPS          = 60,
    parameter int unsigned INTRO_FRAMES = 120,
    parameter int unsigned KO_FRAMES    = 180,
    parameter int unsigned WINS_NEEDED  = 2,
    parameter int unsigned MAX_ROUNDS   = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       SCEN,
    input  logic       start,
    input  logic       p1_hit_event,
    input  logic       p2_hit_event,
    input  logic       p1_hit_heavy,
    input  logic       p2_hit_heavy,
    output logic [7:0] p1_health,
    output logic [7:0] p2_health,
    output logic [2:0] state,
    output logic       fight_enable,
    output logic [6:0] timer_sec,
    output logic [2:0] round_num,
    output logic [1:0] p1_wins,
    output logic [1:0] p2_wins,
    output logic [1:0] round_result,
    output logic [1:0] match_winner
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StIntro    = 3'd1,
        StFight    = 3'd2,
        StKo       = 3'd3,
        StMatchEnd = 3'd4
    } state_e;

    localparam logic [7:0]  HpInit    = 8'(HEALTH);
    localparam logic [7:0]  DmgLight  = 8'(DMG_LIGHT);
    localparam logic [7:0]  DmgHeavy  = 8'(DMG_HEAVY);
    localparam logic [6:0]  TimeInit  = 7'(ROUND_SECS);
    localparam logic [1:0]  WinsN     = 2'(WINS_NEEDED);
    localparam logic [2:0]  RoundsMax = 3'(MAX_ROUNDS);
    localparam logic [15:0] IntroLast = 16'(INTRO_FRAMES - 1);
    localparam logic [15:0] KoLast    = 16'(KO_FRAMES - 1);
    localparam logic [15:0] FpsLast   = 16'(FPS - 1);

    state_e      state_q, state_d;
    logic [7:0]  p1_hp_q, p1_hp_d, p2_hp_q, p2_hp_d;
    logic [6:0]  timer_q, timer_d;
    logic [2:0]  round_q, round_d;
    logic [1:0]  p1_wins_q, p1_wins_d, p2_wins_q, p2_wins_d;
    logic [1:0]  result_q, result_d, winner_q, winner_d;
    logic [15:0] frame_q, frame_d, fps_q, fps_d;
    logic [1:0]  ko_res;

    function automatic logic [7:0] apply_hit(input logic [7:0] hp, input logic ev,
                                             input logic heavy);
        logic [7:0] dmg;
        dmg = heavy ? DmgHeavy : DmgLight;
        if (!ev) return hp;
        return (hp > dmg) ? (hp - dmg) : 8'd0;
    endfunction

    always_comb begin
        state_d   = state_q;
        p1_hp_d   = p1_hp_q;
        p2_hp_d   = p2_hp_q;
        timer_d   = timer_q;
        round_d   = round_q;
        p1_wins_d = p1_wins_q;
        p2_wins_d = p2_wins_q;
        result_d  = result_q;
        winner_d  = winner_q;
        frame_d   = frame_q;
        fps_d     = fps_q;
        ko_res    = 2'd0;
        if (SCEN) begin
            case (state_q)
                StIdle, StMatchEnd: begin
                    if (start) begin
                        state_d   = StIntro;
                        p1_hp_d   = HpInit;
                        p2_hp_d   = HpInit;
                        timer_d   = TimeInit;
                        round_d   = 3'd1;
                        p1_wins_d = 2'd0;
                        p2_wins_d = 2'd0;
                        result_d  = 2'd0;
                        winner_d  = 2'd0;
                        frame_d   = '0;
                        fps_d     = '0;
                    end
                end
                StIntro: begin
                    if (frame_q == IntroLast) begin
                        state_d = StFight;
                        frame_d = '0;
                        fps_d   = '0;
                    end else begin
                        frame_d = frame_q + 16'd1;
                    end
                end
                StFight: begin
                    // KO is judged on the frame after the damage landed
                    if (p1_hp_q == 8'd0 || p2_hp_q == 8'd0) begin
                        ko_res = (p1_hp_q == p2_hp_q) ? 2'd3 :
                                 (p1_hp_q == 8'd0)    ? 2'd2 : 2'd1;
                    end else if (timer_q == 7'd0) begin
                        ko_res = (p1_hp_q > p2_hp_q) ? 2'd1 :
                                 (p2_hp_q > p1_hp_q) ? 2'd2 : 2'd3;
                    end
                    if (ko_res != 2'd0) begin
                        state_d  = StKo;
                        frame_d  = '0;
                        result_d = ko_res;
                        if (ko_res == 2'd1 && p1_wins_q != 2'd3) p1_wins_d = p1_wins_q + 2'd1;
                        if (ko_res == 2'd2 && p2_wins_q != 2'd3) p2_wins_d = p2_wins_q + 2'd1;
                    end else begin
                        p1_hp_d = apply_hit(p1_hp_q, p1_hit_event, p1_hit_heavy);
                        p2_hp_d = apply_hit(p2_hp_q, p2_hit_event, p2_hit_heavy);
                        if (fps_q == FpsLast) begin
                            fps_d   = '0;
                            timer_d = timer_q - 7'd1;
                        end else begin
                            fps_d = fps_q + 16'd1;
                        end
                    end
                end
                StKo: begin
                    if (frame_q == KoLast) begin
                        frame_d = '0;
                        if (p1_wins_q == WinsN || p2_wins_q == WinsN || round_q == RoundsMax) begin
                            state_d  = StMatchEnd;
                            winner_d = (p1_wins_q == WinsN) ? 2'd1 :
                                       (p2_wins_q == WinsN) ? 2'd2 : 2'd3;
                        end else begin
                            state_d  = StIntro;
                            round_d  = round_q + 3'd1;
                            p1_hp_d  = HpInit;
                            p2_hp_d  = HpInit;
                            timer_d  = TimeInit;
                            result_d = 2'd0;
                        end
                    end else begin
                        frame_d = frame_q + 16'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            p1_hp_q   <= HpInit;
            p2_hp_q   <= HpInit;
            timer_q   <= TimeInit;
            round_q   <= 3'd1;
            p1_wins_q <= 2'd0;
            p2_wins_q <= 2'd0;
            result_q  <= 2'd0;
            winner_q  <= 2'd0;
            frame_q   <= '0;
            fps_q     <= '0;
        end else begin
            state_q   <= state_d;
            p1_hp_q   <= p1_hp_d;
            p2_hp_q   <= p2_hp_d;
            timer_q   <= timer_d;
            round_q   <= round_d;
            p1_wins_q <= p1_wins_d;
            p2_wins_q <= p2_wins_d;
            result_q  <= result_d;
            winner_q  <= winner_d;
            frame_q   <= frame_d;
            fps_q     <= fps_d;
        end
    end

    assign state        = state_q;
    assign fight_enable = (state_q == StFight);
    assign p1_health    = p1_hp_q;
    assign p2_health    = p2_hp_q;
    assign timer_sec    = timer_q;
    assign round_num    = round_q;
    assign p1_wins      = p1_wins_q;
    assign p2_wins      = p2_wins_q;
    assign round_result = result_q;
    assign match_winner = winner_q;

endmodule

// File: tb/tb_health_round_ctrl.sv
// Bench for health_round_ctrl: table-driven fight vectors through a scoreboard queue,
// plus hand-written round, KO, time-out, match-end and reset sequences.
module tb_health_round_ctrl;

    logic       clk;
    logic       reset_n;
    logic       SCEN;
    logic       start;
    logic       p1_hit_event, p2_hit_event, p1_hit_heavy, p2_hit_heavy;
    logic [7:0] p1_health, p2_health;
    logic [2:0] state;
    logic       fight_enable;
    logic [6:0] timer_sec;
    logic [2:0] round_num;
    logic [1:0] p1_wins, p2_wins, round_result, match_winner;

    int n_tests = 0;
    int n_fail  = 0;

    health_round_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .SCEN         (SCEN),
        .start        (start),
        .p1_hit_event (p1_hit_event),
        .p2_hit_event (p2_hit_event),
        .p1_hit_heavy (p1_hit_heavy),
        .p2_hit_heavy (p2_hit_heavy),
        .p1_health    (p1_health),
        .p2_health    (p2_health),
        .state        (state),
        .fight_enable (fight_enable),
        .timer_sec    (timer_sec),
        .round_num    (round_num),
        .p1_wins      (p1_wins),
        .p2_wins      (p2_wins),
        .round_result (round_result),
        .match_winner (match_winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       scen;
        logic       p1e, p1h, p2e, p2h;
        logic [7:0] e_p1, e_p2;
        logic [2:0] e_st;
    } vec_t;

    typedef struct {
        int         idx;
        logic [7:0] p1, p2;
        logic [2:0] st;
    } exp_t;

    vec_t vecs[14];
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // One clock with the given inputs; outputs are stable 1 time unit after the edge.
    task automatic frame(input logic scen, input logic p1e, input logic p1h,
                         input logic p2e, input logic p2h);
        SCEN = scen;
        p1_hit_event = p1e;
        p1_hit_heavy = p1h;
        p2_hit_event = p2e;
        p2_hit_heavy = p2h;
        @(posedge clk);
        #1;
        SCEN = 1'b1;
        p1_hit_event = 1'b0;
        p1_hit_heavy = 1'b0;
        p2_hit_event = 1'b0;
        p2_hit_heavy = 1'b0;
        start = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        exp_t e;
        int   n;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd100, 8'd92, 3'd2};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd100, 8'd92, 3'd2};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd85,  8'd92, 3'd2};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd77,  8'd84, 3'd2};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd77,  8'd84, 3'd2};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd69,  8'd69, 3'd2};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd69,  8'd69, 3'd2};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd54,  8'd54, 3'd2};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd39,  8'd39, 3'd2};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd24,  8'd24, 3'd2};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd16,  8'd16, 3'd2};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd8,   8'd8,  3'd2};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0,   8'd0,  3'd2};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   8'd0,  3'd3};

        reset_n = 1'b0;
        SCEN = 1'b1;
        start = 1'b0;
        p1_hit_event = 1'b0;
        p2_hit_event = 1'b0;
        p1_hit_heavy = 1'b0;
        p2_hit_heavy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_p1_health", 32'(p1_health), 32'd100);
        chk("rst_p2_health", 32'(p2_health), 32'd100);
        chk("rst_timer", 32'(timer_sec), 32'd99);
        chk("rst_round", 32'(round_num), 32'd1);
        chk("rst_wins", 32'({p1_wins, p2_wins}), 32'd0);
        chk("rst_result", 32'(round_result), 32'd0);
        chk("rst_winner", 32'(match_winner), 32'd0);
        chk("rst_fight_en", 32'(fight_enable), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Round 1: intro then table-driven hits ending in a double KO.
        start = 1'b1;
        frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("start_to_intro", 32'(state), 32'd1);
        frames(119);
        chk("intro_hold", 32'(state), 32'd1);
        frames(1);
        chk("intro_to_fight", 32'(state), 32'd2);
        chk("fight_enable", 32'(fight_enable), 32'd1);

        for (int i = 0; i < 14; i++) begin
            sb.push_back('{i, vecs[i].e_p1, vecs[i].e_p2, vecs[i].e_st});
            frame(vecs[i].scen, vecs[i].p1e, vecs[i].p1h, vecs[i].p2e, vecs[i].p2h);
            e = sb.pop_front();
            chk($sformatf("vec%0d_p1", e.idx), 32'(p1_health), 32'(e.p1));
            chk($sformatf("vec%0d_p2", e.idx), 32'(p2_health), 32'(e.p2));
            chk($sformatf("vec%0d_state", e.idx), 32'(state), 32'(e.st));
        end
        chk("draw_result", 32'(round_result), 32'd3);
        chk("draw_wins", 32'({p1_wins, p2_wins}), 32'd0);
        frames(179);
        chk("ko_hold", 32'(state), 32'd3);
        frames(1);
        chk("ko_to_intro", 32'(state), 32'd1);
        chk("round2_num", 32'(round_num), 32'd2);
        chk("round2_hp", 32'({p1_health, p2_health}), 32'({8'd100, 8'd100}));
        chk("round2_result", 32'(round_result), 32'd0);
        chk("round2_timer", 32'(timer_sec), 32'd99);

        // Round 2: heavy hit saturates p1 at zero.
        frames(120);
        chk("r2_fight", 32'(state), 32'd2);
        for (int i = 0; i < 6; i++) frame(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("sat_pre", 32'(p1_health), 32'd10);
        frame(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("sat_zero", 32'(p1_health), 32'd0);
        frames(1);
        chk("sat_ko", 32'(state), 32'd3);
        chk("sat_result", 32'(round_result), 32'd2);
        chk("sat_p2_wins", 32'(p2_wins), 32'd1);
        frames(180);
        chk("round3_num", 32'(round_num), 32'd3);

        // Round 3: time-out with p1 ahead.
        frames(120);
        frame(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("to_p2_hp", 32'(p2_health), 32'd92);
        frames(58);
        chk("timer_59f", 32'(timer_sec), 32'd99);
        frames(1);
        chk("timer_60f", 32'(timer_sec), 32'd98);
        n = 0;
        while (state != 3'd3 && n < 7000) begin
            frames(1);
            n++;
        end
        chk("to_frames", 32'(n), 32'd5881);
        chk("to_timer", 32'(timer_sec), 32'd0);
        chk("to_result", 32'(round_result), 32'd1);
        chk("to_p1_wins", 32'(p1_wins), 32'd1);
        frame(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("ko_hit_p1", 32'(p1_health), 32'd100);
        chk("ko_hit_p2", 32'(p2_health), 32'd92);
        frames(179);
        chk("round4_num", 32'(round_num), 32'd4);

        // Round 4: p1 takes its second round, match ends.
        frames(120);
        for (int i = 0; i < 7; i++) frame(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("r4_p2_zero", 32'(p2_health), 32'd0);
        frames(1);
        chk("r4_p1_wins", 32'(p1_wins), 32'd2);
        frames(179);
        chk("r4_ko_hold", 32'(state), 32'd3);
        frames(1);
        chk("match_end", 32'(state), 32'd4);
        chk("match_winner", 32'(match_winner), 32'd1);
        start = 1'b1;
        frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("restart_state", 32'(state), 32'd1);
        chk("restart_hp", 32'({p1_health, p2_health}), 32'({8'd100, 8'd100}));
        chk("restart_wins", 32'({p1_wins, p2_wins}), 32'd0);
        chk("restart_winner", 32'(match_winner), 32'd0);
        chk("restart_result", 32'(round_result), 32'd0);
        chk("restart_round", 32'(round_num), 32'd1);

        // Asynchronous reset mid-fight.
        frames(120);
        frame(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("pre_rst_p2", 32'(p2_health), 32'd92);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_p2", 32'(p2_health), 32'd100);
        chk("arst_fight_en", 32'(fight_enable), 32'd0);
        chk("arst_timer", 32'(timer_sec), 32'd99);
        chk("arst_wins", 32'({p1_wins, p2_wins}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
